instr_fetch_unit: RTL and testbench

- Fetch stage of the FRiscV CPU; sits directly upstream of the main controller and datapath.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Holds the returned instruction in an instruction register and presents the decoded fields: op_code, func3, func7 (instr[31:25], which is imm[11:5] for I-type), and rd/rs1/rs2.
- Advances to PC+4 or to a datapath-supplied redirect target when the current instruction is consumed.

---
 rtl/friscv_pkg.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/friscv_pkg.sv
// Shared FRiscV definitions: fetch FSM states, instruction field positions and opcodes.
package friscv_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNC3_LSB  = 12;
    localparam int FUNC3_MSB  = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNC7_LSB  = 25;
    localparam int FUNC7_MSB  = 31;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return addr_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// FRiscV fetch stage: owns the PC, fetches one word at a time and holds it for decode.
// Optional FETCH_PERF_CNT_EN adds fetch_count_out / wait_cycles_out performance counters.
module instr_fetch_unit
    import friscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [31:0]     imem_rdata_in,
    input  logic            stall_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic            instr_valid_out,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic [6:0]      op_code_out,
    output logic [2:0]      func3_out,
    output logic [6:0]      func7_out,
    output logic [4:0]      rd_addr_out,
    output logic [4:0]      rs1_addr_out,
    output logic [4:0]      rs2_addr_out,
    output logic            misalign_err_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     fetch_count_out,
    output logic [31:0]     wait_cycles_out,
`endif
    output fetch_state_t    state_out
);

    // Memory handshake: a request is offered while imem_req_out=1 and is taken on the
    // cycle imem_gnt_in=1; its single response arrives later as one imem_rvalid_in pulse.
    // Downstream consumes the held instruction on any cycle in HOLD with stall_in=0.

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            imem_req;
    logic            misalign_err;
    logic            consume;

    assign consume = (state == HOLD) && !stall_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= REQ;
            pc           <= RESET_PC;
            instr        <= INSTR_NOP;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    // Request is held low for the first cycle after reset; any response
                    // arriving here belongs to an abandoned fetch and is dropped.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_gnt_in) begin
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_in) begin
                        instr       <= imem_rdata_in;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        instr_valid <= 1'b0;
                        if (redirect_in && !is_word_aligned(redirect_pc_in[1:0])) begin
                            misalign_err <= 1'b1;
                            state        <= ERR;
                        end else begin
                            pc       <= redirect_in ? redirect_pc_in : pc_plus4_out;
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= ERR;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_cycles;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_count <= '0;
            wait_cycles <= '0;
        end else begin
            if (consume) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (((state == REQ) && !(imem_req && imem_gnt_in)) ||
                ((state == WAIT) && !imem_rvalid_in)) begin
                wait_cycles <= wait_cycles + 32'd1;
            end
        end
    end

    assign fetch_count_out = fetch_count;
    assign wait_cycles_out = wait_cycles;
`endif

    assign imem_req_out     = imem_req;
    assign imem_addr_out    = pc;
    assign pc_out           = pc;
    assign pc_plus4_out     = pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign instr_valid_out  = instr_valid;
    assign instr_out        = instr;
    assign misalign_err_out = misalign_err;
    assign state_out        = state;

    assign op_code_out  = instr[OPCODE_MSB:OPCODE_LSB];
    assign rd_addr_out  = instr[RD_MSB:RD_LSB];
    assign func3_out    = instr[FUNC3_MSB:FUNC3_LSB];
    assign rs1_addr_out = instr[RS1_MSB:RS1_LSB];
    assign rs2_addr_out = instr[RS2_MSB:RS2_LSB];
    assign func7_out    = instr[FUNC7_MSB:FUNC7_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a bench-side memory model grants and returns
// words, and a scoreboard queue of {address, word} is checked against each held instruction.
module tb_instr_fetch_unit;
  import friscv_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic imem_req_out;
  logic [31:0] imem_addr_out;
  logic imem_gnt_in = 1'b0;
  logic imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic stall_in = 1'b0;
  logic redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [6:0] op_code_out;
  logic [2:0] func3_out;
  logic [6:0] func7_out;
  logic [4:0] rd_addr_out;
  logic [4:0] rs1_addr_out;
  logic [4:0] rs2_addr_out;
  logic misalign_err_out;
  fetch_state_t state_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_out;
  logic [31:0] wait_cycles_out;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] cur_pc;
  logic [31:0] cur_instr;
  int model_fetch_count;

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .imem_req_out(imem_req_out),
    .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in),
    .imem_rvalid_in(imem_rvalid_in),
    .imem_rdata_in(imem_rdata_in),
    .stall_in(stall_in),
    .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in),
    .instr_valid_out(instr_valid_out),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out),
    .op_code_out(op_code_out),
    .func3_out(func3_out),
    .func7_out(func7_out),
    .rd_addr_out(rd_addr_out),
    .rs1_addr_out(rs1_addr_out),
    .rs2_addr_out(rs2_addr_out),
    .misalign_err_out(misalign_err_out),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count_out(fetch_count_out),
    .wait_cycles_out(wait_cycles_out),
`endif
    .state_out(state_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory driver: waits for a request, optionally delays the grant with stray rvalids,
  // then returns word after rv_delay extra cycles and checks the held instruction
  task automatic serve(input logic [31:0] word, input int gnt_delay, input bit stray_rvalid,
                       input int rv_delay);
    int waited = 0;
    logic [63:0] exp;
    while (imem_req_out !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    tests_run++;
    if (imem_req_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_timeout: req=%b after %0d cycles, required 1", imem_req_out, waited);
      return;
    end
    tests_run++;
    if (imem_addr_out !== model_pc) begin
      tests_failed++;
      $display("FAIL req_addr: got %h, required %h", imem_addr_out, model_pc);
    end
    for (int i = 0; i < gnt_delay; i++) begin
      imem_rvalid_in = stray_rvalid;
      imem_rdata_in = 32'hDEAD_BEEF;
      tick();
      tests_run++;
      if ({imem_req_out, imem_addr_out} !== {1'b1, model_pc}) begin
        tests_failed++;
        $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h",
                 imem_req_out, imem_addr_out, model_pc);
      end
    end
    imem_rvalid_in = 1'b0;
    imem_gnt_in = 1'b1;
    exp_q.push_back({model_pc, word});
    tick();
    imem_gnt_in = 1'b0;
    tests_run++;
    if ({imem_req_out, instr_valid_out} !== 2'b00) begin
      tests_failed++;
      $display("FAIL wait_outputs: req=%b valid=%b, required 0 0", imem_req_out, instr_valid_out);
    end
    for (int i = 0; i < rv_delay; i++) begin
      tick();
      tests_run++;
      if (state_out !== WAIT || imem_req_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL wait_state: state=%0d req=%b, required WAIT req=0", state_out, imem_req_out);
      end
    end
    imem_rvalid_in = 1'b1;
    imem_rdata_in = word;
    tick();
    imem_rvalid_in = 1'b0;
    imem_rdata_in = '0;
    tests_run++;
    if (instr_valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_valid: valid=%b, required 1", instr_valid_out);
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: size=0, required 1 entry");
      return;
    end
    exp = exp_q.pop_front();
    cur_pc = exp[63:32];
    cur_instr = exp[31:0];
    if ({pc_out, instr_out, pc_plus4_out} !== {cur_pc, cur_instr, cur_pc + 32'd4}) begin
      tests_failed++;
      $display("FAIL hold_data: pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
               pc_out, instr_out, pc_plus4_out, cur_pc, cur_instr, cur_pc + 32'd4);
    end
    tests_run++;
    if ({func7_out, rs2_addr_out, rs1_addr_out, func3_out, rd_addr_out, op_code_out}
        !== cur_instr) begin
      tests_failed++;
      $display("FAIL fields: f7=%h rs2=%0d rs1=%0d f3=%0d rd=%0d op=%h, required instr %h",
               func7_out, rs2_addr_out, rs1_addr_out, func3_out, rd_addr_out, op_code_out,
               cur_instr);
    end
  endtask

  // downstream driver: stalls (with ignored redirect noise), then consumes
  task automatic consume(input int stall_cycles, input bit redirect, input logic [31:0] target);
    for (int i = 0; i < stall_cycles; i++) begin
      stall_in = 1'b1;
      redirect_in = 1'b1;
      redirect_pc_in = 32'h0000_0055;
      tick();
      tests_run++;
      if ({instr_valid_out, imem_req_out, pc_out, instr_out} !== {2'b10, cur_pc, cur_instr}) begin
        tests_failed++;
        $display("FAIL stall_hold: valid=%b req=%b pc=%h instr=%h, required 1 0 %h %h",
                 instr_valid_out, imem_req_out, pc_out, instr_out, cur_pc, cur_instr);
      end
    end
    stall_in = 1'b0;
    redirect_in = redirect;
    redirect_pc_in = target;
    tick();
    redirect_in = 1'b0;
    redirect_pc_in = '0;
    model_fetch_count++;
    if (redirect && target[1:0] != 2'b00) begin
      tests_run++;
      if ({misalign_err_out, instr_valid_out, state_out} !== {2'b10, ERR}) begin
        tests_failed++;
        $display("FAIL misalign: err=%b valid=%b state=%0d, required 1 0 ERR",
                 misalign_err_out, instr_valid_out, state_out);
      end
    end else begin
      model_pc = redirect ? target : model_pc + 32'd4;
      tests_run++;
      if ({misalign_err_out, instr_valid_out, pc_out} !== {2'b00, model_pc}) begin
        tests_failed++;
        $display("FAIL consume: err=%b valid=%b pc=%h, required 0 0 %h",
                 misalign_err_out, instr_valid_out, pc_out, model_pc);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (fetch_count_out !== 32'(model_fetch_count)) begin
      tests_failed++;
      $display("FAIL fetch_count: got %0d, required %0d", fetch_count_out, model_fetch_count);
    end
`endif
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    stall_in = 1'b0;
    imem_gnt_in = 1'b0;
    imem_rvalid_in = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({imem_req_out, instr_valid_out, misalign_err_out, instr_out, pc_out, pc_plus4_out}
        !== {3'b000, INSTR_NOP, RESET_PC, RESET_PC + 32'd4} || state_out !== REQ) begin
      tests_failed++;
      $display("FAIL reset_values: req=%b valid=%b err=%b instr=%h pc=%h pc4=%h state=%0d",
               imem_req_out, instr_valid_out, misalign_err_out, instr_out, pc_out,
               pc_plus4_out, state_out);
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if ({fetch_count_out, wait_cycles_out} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: fetch=%0d wait=%0d, required 0 0",
               fetch_count_out, wait_cycles_out);
    end
`endif
    rst_in = 1'b0;
    tick();
    tests_run++;
    if ({imem_req_out, imem_addr_out} !== {1'b1, RESET_PC}) begin
      tests_failed++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1 %h",
               imem_req_out, imem_addr_out, RESET_PC);
    end
    model_pc = RESET_PC;
    model_fetch_count = 0;
    exp_q.delete();
  endtask

  task automatic test_first_fetch();
    serve(32'h0030_0093, 0, 1'b0, 0);
    tests_run++;
    if ({op_code_out, rd_addr_out, func3_out, rs1_addr_out} !== {OPC_OP_IMM, 5'd1, 3'd0, 5'd0}) begin
      tests_failed++;
      $display("FAIL addi_fields: op=%h rd=%0d f3=%0d rs1=%0d, required 13 1 0 0",
               op_code_out, rd_addr_out, func3_out, rs1_addr_out);
    end
    consume(0, 1'b0, '0);
  endtask

  task automatic test_sequential();
    serve(32'h00B5_0533, 0, 1'b0, 0);
    consume(0, 1'b0, '0);
    serve(32'h4020_8133, 0, 1'b0, 0);
    consume(0, 1'b0, '0);
    serve(32'hFFC1_2083, 0, 1'b0, 0);
    consume(0, 1'b0, '0);
  endtask

  task automatic test_gnt_delay();
    serve(32'h0000_0073, 4, 1'b1, 2);
    consume(0, 1'b0, '0);
  endtask

  task automatic test_stall_redirect();
    serve(32'h0080_006F, 0, 1'b0, 0);
    consume(5, 1'b1, 32'h0000_0100);
    serve(32'h0000_0013, 0, 1'b0, 0);
    consume(0, 1'b1, 32'hFFFF_FFFC);
  endtask

  task automatic test_wrap();
    serve(32'h0010_0113, 0, 1'b0, 0);
    consume(0, 1'b0, '0);
    serve(32'h0000_0013, 1, 1'b0, 1);
    consume(2, 1'b0, '0);
  endtask

  task automatic test_misalign();
    serve(32'h0000_8067, 0, 1'b0, 0);
    consume(0, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 6; i++) begin
      imem_gnt_in = 1'b1;
      imem_rvalid_in = 1'b1;
      tick();
      tests_run++;
      if ({imem_req_out, instr_valid_out, misalign_err_out} !== 3'b001 || state_out !== ERR) begin
        tests_failed++;
        $display("FAIL err_sticky: req=%b valid=%b err=%b state=%0d, required 0 0 1 ERR",
                 imem_req_out, instr_valid_out, misalign_err_out, state_out);
      end
    end
    imem_gnt_in = 1'b0;
    imem_rvalid_in = 1'b0;
    test_reset();
    serve(32'h0030_0093, 0, 1'b0, 0);
    consume(0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] word;
    for (int i = 0; i < 8; i++) begin
      word = $urandom();
      serve(word, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      consume($urandom_range(0, 2), 1'b0, '0);
    end
  endtask

  initial begin
    model_pc = RESET_PC;
    model_fetch_count = 0;
    cur_pc = '0;
    cur_instr = '0;
    test_reset();
    test_first_fetch();
    test_reset();
    test_sequential();
    test_gnt_delay();
    test_stall_redirect();
    test_wrap();
    test_misalign();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
